// File: rtl/pwm_ramp_sched_if.sv
// Register-write bus from the I2C register decoder into the ramp scheduler.
// The decoder drives the master side; the scheduler receives on the slave side.
interface pwm_ramp_sched_if #(
    parameter int AW = 2
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_sel;
    logic [15:0]   wr_data;

    modport master (output wr_en, output wr_addr, output wr_sel, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_sel, input  wr_data);
endinterface

// File: rtl/pwm_ramp_sched.sv
// Multi-channel duty scheduler: per-channel target/step/current registers,
// one shared ramp adder swept across all channels once per prescaled tick.
module pwm_ramp_chan (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_tgt,
    input  logic        wr_step,
    input  logic        wr_cur,
    input  logic [15:0] wr_data,
    input  logic        upd,
    input  logic [15:0] upd_val,
    output logic [15:0] cur,
    output logic [15:0] tgt,
    output logic [15:0] step,
    output logic        active
);
    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= '0;
            tgt    <= '0;
            step   <= '0;
            active <= 1'b0;
        end else begin
            if (wr_tgt)  tgt  <= wr_data;
            if (wr_step) step <= wr_data;
            // A direct current write overrides a ramp result landing in the same cycle.
            if (wr_cur)   cur <= wr_data;
            else if (upd) cur <= upd_val;
            active <= (cur != tgt);
        end
    end
endmodule

module pwm_ramp_sched #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 256,
    parameter int AW       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    pwm_ramp_sched_if.slave          wr,
    output logic [16*CHANNELS-1:0]   duty_out,
    output logic [CHANNELS-1:0]      ramp_active,
    output logic                     sweep_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic          scan_en;

    logic [CHANNELS-1:0][15:0] cur_q, tgt_q, step_q;
    logic [15:0] sel_c, sel_t, sel_s, ramp_val;
    logic [16:0] sum, diff;

    assign tick = (presc_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) presc_q <= '0;
        else       presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        scan_en    = 1'b0;
        sweep_done = 1'b0;
        case (state_q)
            IDLE: if (tick) begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: begin
                scan_en = 1'b1;
                if (idx_q == AW'(CHANNELS - 1)) state_d = DONE;
                else                            idx_d   = idx_q + 1'b1;
            end
            DONE: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_c = '0;
        sel_t = '0;
        sel_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == AW'(i)) begin
                sel_c = cur_q[i];
                sel_t = tgt_q[i];
                sel_s = step_q[i];
            end
        end
    end

    // 17-bit sum/difference so overshoot in either direction clamps to target.
    assign sum  = {1'b0, sel_c} + {1'b0, sel_s};
    assign diff = {1'b0, sel_c} - {1'b0, sel_s};

    always_comb begin
        ramp_val = sel_c;
        if (sel_s == 16'd0)
            ramp_val = sel_t;
        else if (sel_c < sel_t)
            ramp_val = (sum >= {1'b0, sel_t}) ? sel_t : sum[15:0];
        else if (sel_c > sel_t)
            ramp_val = (diff[16] || diff[15:0] <= sel_t) ? sel_t : diff[15:0];
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit = wr.wr_en && (wr.wr_addr == AW'(g));

        pwm_ramp_chan u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_tgt  (hit && wr.wr_sel == 2'd0),
            .wr_step (hit && wr.wr_sel == 2'd1),
            .wr_cur  (hit && wr.wr_sel == 2'd2),
            .wr_data (wr.wr_data),
            .upd     (scan_en && idx_q == AW'(g)),
            .upd_val (ramp_val),
            .cur     (cur_q[g]),
            .tgt     (tgt_q[g]),
            .step    (step_q[g]),
            .active  (ramp_active[g])
        );
    end

    assign duty_out = cur_q;
endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Directed bench for pwm_ramp_sched at CHANNELS=4, PRESCALE=8.
module tb_pwm_ramp_sched;
    logic        clk;
    logic        reset;
    logic [63:0] duty_out;
    logic [3:0]  ramp_active;
    logic        sweep_done;
    int          errors = 0;
    int          checks = 0;

    pwm_ramp_sched_if #(.AW(2)) bus ();

    pwm_ramp_sched #(.CHANNELS(4), .PRESCALE(8), .AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (bus.slave),
        .duty_out    (duty_out),
        .ramp_active (ramp_active),
        .sweep_done  (sweep_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] duty(input int ch);
        return duty_out[16*ch +: 16];
    endfunction

    // Caller sits at a negedge; the write is sampled at the following posedge.
    task automatic wr(input int ch, input logic [1:0] sel, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'(ch);
        bus.wr_sel  = sel;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Advance to the negedge inside the next DONE cycle (prescaler phase 4).
    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!sweep_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sweep_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: sweep_done=%b after %0d cycles, expected 1", sweep_done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (duty_out !== 64'd0 || ramp_active !== 4'd0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: duty=%h act=%b done=%b, expected all 0", duty_out, ramp_active, sweep_done);
        end
    endtask

    task automatic test_idle_period();
        int n;
        wait_done();
        @(negedge clk);
        checks++;
        if (sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: sweep_done=%b one cycle later, expected 0", sweep_done);
        end
        n = 1;
        while (!sweep_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL done_period: got %0d cycles, expected 8", n);
        end
        checks++;
        if (duty_out !== 64'd0 || ramp_active !== 4'd0) begin
            errors++;
            $display("FAIL idle_outputs: duty=%h act=%b, expected 0", duty_out, ramp_active);
        end
    endtask

    task automatic test_ramp_up();
        logic [15:0] exp_d [5] = '{16'h1000, 16'h2000, 16'h3000, 16'h3800, 16'h3800};
        logic        exp_a [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        wait_done();
        wr(0, 2'd1, 16'h1000);
        wr(0, 2'd0, 16'h3800);
        for (int i = 0; i < 5; i++) begin
            wait_done();
            checks++;
            if (duty(0) !== exp_d[i] || ramp_active[0] !== exp_a[i]) begin
                errors++;
                $display("FAIL ramp_up[%0d]: duty0=%h act0=%b, expected %h/%b", i, duty(0), ramp_active[0], exp_d[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_clamp();
        wait_done();
        wr(1, 2'd2, 16'hFFF0);
        checks++;
        if (duty(1) !== 16'hFFF0) begin
            errors++;
            $display("FAIL cur_write_latency: duty1=%h, expected fff0", duty(1));
        end
        wr(1, 2'd0, 16'h0000);
        wr(1, 2'd1, 16'h8000);
        wait_done();
        checks++;
        if (duty(1) !== 16'h7FF0) begin
            errors++;
            $display("FAIL ramp_down1: duty1=%h, expected 7ff0", duty(1));
        end
        wait_done();
        checks++;
        if (duty(1) !== 16'h0000) begin
            errors++;
            $display("FAIL no_underflow: duty1=%h, expected 0000", duty(1));
        end
        wr(1, 2'd0, 16'hFFFF);
        wr(1, 2'd1, 16'hFFFF);
        wait_done();
        checks++;
        if (duty(1) !== 16'hFFFF) begin
            errors++;
            $display("FAIL full_step: duty1=%h, expected ffff", duty(1));
        end
        wr(1, 2'd2, 16'h8000);
        wait_done();
        checks++;
        if (duty(1) !== 16'hFFFF || ramp_active[1] !== 1'b0) begin
            errors++;
            $display("FAIL no_wrap: duty1=%h act1=%b, expected ffff/0", duty(1), ramp_active[1]);
        end
    endtask

    task automatic test_step_zero();
        wait_done();
        wr(2, 2'd1, 16'h0000);
        wr(2, 2'd0, 16'h1234);
        checks++;
        if (duty(2) !== 16'h0000) begin
            errors++;
            $display("FAIL jump_early: duty2=%h before tick, expected 0000", duty(2));
        end
        wait_done();
        checks++;
        if (duty(2) !== 16'h1234 || ramp_active[2] !== 1'b0) begin
            errors++;
            $display("FAIL step_zero_jump: duty2=%h act2=%b, expected 1234/0", duty(2), ramp_active[2]);
        end
    endtask

    task automatic test_ignored_write();
        wait_done();
        wr(0, 2'd3, 16'h5555);
        wait_done();
        checks++;
        if (duty(0) !== 16'h3800 || ramp_active[0] !== 1'b0) begin
            errors++;
            $display("FAIL sel3_ignored: duty0=%h act0=%b, expected 3800/0", duty(0), ramp_active[0]);
        end
    endtask

    task automatic test_collision();
        wait_done();
        wr(3, 2'd1, 16'h0010);
        wr(3, 2'd0, 16'h8000);
        wait_done();
        checks++;
        if (duty(3) !== 16'h0010) begin
            errors++;
            $display("FAIL ch3_first_step: duty3=%h, expected 0010", duty(3));
        end
        // From phase 4, seven cycles lands in phase 3: the cycle ch3 is scanned.
        repeat (7) @(negedge clk);
        wr(3, 2'd2, 16'h0100);
        checks++;
        if (duty(3) !== 16'h0100 || sweep_done !== 1'b1) begin
            errors++;
            $display("FAIL collision_write_wins: duty3=%h done=%b, expected 0100/1", duty(3), sweep_done);
        end
        wait_done();
        checks++;
        if (duty(3) !== 16'h0110 || ramp_active[3] !== 1'b1) begin
            errors++;
            $display("FAIL collision_resume: duty3=%h act3=%b, expected 0110/1", duty(3), ramp_active[3]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        wait_done();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (duty_out !== 64'd0 || ramp_active !== 4'd0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan: duty=%h act=%b done=%b, expected all 0", duty_out, ramp_active, sweep_done);
        end
        n = 0;
        while (!sweep_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL scan_restart: first sweep_done after %0d cycles, expected 12", n);
        end
        checks++;
        if (duty_out !== 64'd0) begin
            errors++;
            $display("FAIL post_reset_duty: duty=%h, expected 0", duty_out);
        end
    endtask

    initial begin
        test_reset();
        test_idle_period();
        test_ramp_up();
        test_clamp();
        test_step_zero();
        test_ignored_write();
        test_collision();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
